multiword_add_ctrl: RTL and testbench
=====================================

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning word width in bits of every operand and sum word.
REQ-002 The block SHALL have parameter SETTLE, default 2, legal range 1..15, meaning the number of cycles the external ripple-carry adder is given to settle.
REQ-003 Port clk, input, 1, meaning the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n, input, 1, meaning reset; it SHALL be asynchronous and active-low.
REQ-005 Port in_valid, input, 1, meaning the upstream word is valid.
REQ-006 Port in_ready, output, 1, meaning the block can accept a word.
REQ-007 Ports in_a and in_b, input, N each, meaning the operand words, least-significant word first.
REQ-008 Port in_first, input, 1, meaning this word starts a new multi-word operand.
REQ-009 Port in_last, input, 1, meaning this word ends the operand.
REQ-010 Ports add_a and add_b (output, N each) and add_cin (output, 1) SHALL drive the external N-bit ripple-carry adder.
REQ-011 Ports add_sum (input, N) and add_cout (input, 1) SHALL carry the adder results.
REQ-012 Port out_valid, output, 1, meaning the result word is valid.
REQ-013 Port out_ready, input, 1, meaning downstream accepts the result.
REQ-014 Ports out_sum (N), out_cout (1), out_last (1) and out_idx (8), all outputs, meaning the sum word, the carry out of this word, the last-word flag, and the word index within the operand.

Function
REQ-015 The block SHALL implement FSM states IDLE, SETTLE and OUT.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in OUT.
REQ-017 In IDLE, in_valid=1 SHALL constitute acceptance; on acceptance the block SHALL register in_a/in_b onto add_a/add_b, register add_cin, load settle_cnt=SETTLE-1 and go to SETTLE.
REQ-018 add_cin on acceptance SHALL be 0 if eff_first is 1, else the stored chain carry; eff_first = in_first OR chain_idle.
REQ-019 chain_idle SHALL be 1 after reset and after a word with in_last=1 is accepted, and SHALL be cleared by accepting a word with in_last=0.
REQ-020 In SETTLE, settle_cnt SHALL decrement each cycle.
REQ-021 At the edge where settle_cnt=0, the block SHALL capture add_sum into out_sum, add_cout into out_cout and into the chain carry, and the latched last flag into out_last, then go to OUT.
REQ-022 out_valid SHALL therefore rise exactly SETTLE cycles after the accepting edge.
REQ-023 add_a, add_b and add_cin SHALL remain stable from acceptance until the capture edge inclusive.
REQ-024 In OUT, all out_* outputs SHALL hold stable while out_ready=0; on out_ready=1 the block SHALL return to IDLE.
REQ-025 A new word SHALL not be accepted in the same cycle as an OUT handshake; minimum throughput is one word per SETTLE+2 cycles.
REQ-026 out_idx SHALL be 0 for an eff_first word and previous index+1 otherwise, wrapping modulo 256 from 255 to 0.
REQ-027 in_first=1 on a mid-operand word SHALL restart the chain: cin=0 and idx=0, with no error raised.
REQ-028 in_a, in_b, in_first and in_last SHALL be ignored when no acceptance occurs.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and set in_ready=1 at the next evaluation.
REQ-030 rst_n=0 SHALL immediately clear out_valid, out_sum, out_cout, out_last, out_idx, add_a, add_b, add_cin, the chain carry and settle_cnt to 0, and set chain_idle=1.
REQ-031 Reset asserted in SETTLE or OUT SHALL discard the in-flight word; the first word after release SHALL be treated as first.

Verification (N=8, SETTLE=2, behavioural adder model on add_*)
REQ-032 A single word a=0x3C, b=0x05, first=last=1 -> out_valid two cycles after acceptance with out_sum=0x41, out_cout=0, out_idx=0, out_last=1.
REQ-033 A two-word operand 0x12FF+0x0001 (words FF/01, then 12/00) -> word0 sum=0x00, cout=1, idx=0; word1 add_cin=1, sum=0x13, cout=0, idx=1, last=1.
REQ-034 out_ready held 0 for 5 cycles in OUT -> outputs stable, in_ready=0 throughout; the handshake then returns the block to IDLE the next cycle.
REQ-035 A word with in_first=0 immediately after a last word with carry 1 -> add_cin=0 and idx=0.
REQ-036 rst_n pulsed low during SETTLE of word 1 of a chain -> all outputs 0 asynchronously; the next word gets add_cin=0 and idx=0.
REQ-037 A 257-word chain with FF+01 words -> every word after the first has add_cin=1, and out_idx wraps 255 to 0.

Source files
------------

// File: rtl/multiword_add_ctrl.sv
// Sequencer that feeds a multi-word add through an external N-bit ripple-carry adder,
// one word at a time. It holds each word steady while the adder settles and chains the carry between words.
module multiword_add_ctrl #(
  parameter int N      = 8,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_first,
  input  logic         in_last,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_last,
  output logic [7:0]   out_idx
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_OUT} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       chain_carry;
  logic       chain_idle;
  logic       last_lat;
  logic [7:0] idx_lat;

  logic accept;
  logic capture;
  logic eff_first;

  assign accept    = (state == S_IDLE) && in_valid;
  assign capture   = (state == S_SETTLE) && (settle_cnt == 4'd0);
  assign eff_first = in_first | chain_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt == 4'd0) state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Acceptance stage: operands are frozen on add_* until the capture edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a       <= '0;
      add_b       <= '0;
      add_cin     <= 1'b0;
      settle_cnt  <= 4'd0;
      idx_lat     <= 8'd0;
      last_lat    <= 1'b0;
      chain_idle  <= 1'b1;
      chain_carry <= 1'b0;
      out_sum     <= '0;
      out_cout    <= 1'b0;
      out_last    <= 1'b0;
      out_idx     <= 8'd0;
    end else if (accept) begin
      add_a      <= in_a;
      add_b      <= in_b;
      add_cin    <= eff_first ? 1'b0 : chain_carry;
      idx_lat    <= eff_first ? 8'd0 : idx_lat + 8'd1;
      last_lat   <= in_last;
      chain_idle <= in_last;
      settle_cnt <= SETTLE_INIT;
    end else if (capture) begin
      // Capture stage: adder has settled, take the result and carry
      out_sum     <= add_sum;
      out_cout    <= add_cout;
      chain_carry <= add_cout;
      out_last    <= last_lat;
      out_idx     <= idx_lat;
    end else if (state == S_SETTLE) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Randomized and directed bench for multiword_add_ctrl with a behavioural adder on add_*.
// Expected values come from a word-level model of the carry chain.
module tb_multiword_add_ctrl;

  localparam int N      = 8;
  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_first, in_last;
  logic [N-1:0] in_a, in_b;
  logic [N-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid, out_ready, out_cout, out_last;
  logic [N-1:0] out_sum;
  logic [7:0]   out_idx;
  logic [N:0]   adder_res;

  int n_checks = 0;
  int n_errors = 0;

  // word-level reference state
  logic       m_carry, m_idle;
  logic [7:0] m_idx;
  logic [7:0] e_a, e_b, e_sum, e_idx;
  logic       e_cin, e_cout, e_last;

  always #5 clk = ~clk;

  always_comb begin
    adder_res = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
    add_sum   = adder_res[N-1:0];
    add_cout  = adder_res[N];
  end

  multiword_add_ctrl #(.N(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_last(out_last), .out_idx(out_idx)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_carry = 1'b0;
    m_idle  = 1'b1;
    m_idx   = 8'd0;
  endtask

  task automatic accept_word(input logic [7:0] a, input logic [7:0] b,
                             input logic first, input logic last);
    int w;
    int s;
    logic eff;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_val("in_ready_wait", in_ready, 1);
    in_a = a; in_b = b; in_first = first; in_last = last; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom);
    in_first = 1'($urandom); in_last = 1'($urandom);
    eff    = first | m_idle;
    e_a    = a;
    e_b    = b;
    e_cin  = eff ? 1'b0 : m_carry;
    e_idx  = eff ? 8'd0 : m_idx + 8'd1;
    s      = int'(a) + int'(b) + int'(e_cin);
    e_sum  = s[7:0];
    e_cout = s[8];
    e_last = last;
    m_carry = e_cout;
    m_idx   = e_idx;
    m_idle  = last;
    check_val("acc_add_a", add_a, e_a);
    check_val("acc_add_b", add_b, e_b);
    check_val("acc_add_cin", add_cin, e_cin);
  endtask

  task automatic finish_word(input int hold);
    int cyc;
    logic [7:0] s_sum, s_idx;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      check_val("busy_in_ready", in_ready, 0);
      check_val("hold_add_a", add_a, e_a);
      check_val("hold_add_cin", add_cin, e_cin);
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("cap_add_b", add_b, e_b);
    check_val("cap_add_cin", add_cin, e_cin);
    check_val("latency", cyc, SETTLE);
    check_val("out_valid", out_valid, 1);
    check_val("out_sum", out_sum, e_sum);
    check_val("out_cout", out_cout, e_cout);
    check_val("out_idx", out_idx, e_idx);
    check_val("out_last", out_last, e_last);
    s_sum = out_sum;
    s_idx = out_idx;
    repeat (hold) begin
      @(posedge clk);
      #1;
      check_val("stall_valid", out_valid, 1);
      check_val("stall_in_ready", in_ready, 0);
      check_val("stall_sum", out_sum, s_sum);
      check_val("stall_idx", out_idx, s_idx);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val("post_hs_valid", out_valid, 0);
    check_val("post_hs_ready", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_sum", out_sum, 0);
    check_val("rst_out_idx", out_idx, 0);
    check_val("rst_add_a", add_a, 0);
    check_val("rst_add_cin", add_cin, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single word
    accept_word(8'h3C, 8'h05, 1'b1, 1'b1);
    check_val("single_exp_sum", e_sum, 8'h41);
    finish_word(0);

    // two-word operand 0x12FF + 0x0001
    accept_word(8'hFF, 8'h01, 1'b1, 1'b0);
    finish_word(0);
    accept_word(8'h12, 8'h00, 1'b0, 1'b1);
    check_val("two_word_cin", add_cin, 1);
    finish_word(0);

    // downstream stall
    accept_word(8'($urandom), 8'($urandom), 1'b1, 1'b1);
    finish_word(5);

    // carry must not leak across a finished operand
    accept_word(8'hFF, 8'h01, 1'b1, 1'b1);
    finish_word(0);
    accept_word(8'h10, 8'h20, 1'b0, 1'b0);
    check_val("after_last_cin", add_cin, 0);
    finish_word(1);
    accept_word(8'h01, 8'h02, 1'b0, 1'b1);
    finish_word(0);

    // mid-operand restart via in_first
    accept_word(8'hFF, 8'h01, 1'b1, 1'b0);
    finish_word(0);
    accept_word(8'h05, 8'h06, 1'b1, 1'b1);
    finish_word(0);

    // reset during SETTLE of word 1
    accept_word(8'hFF, 8'h01, 1'b1, 1'b0);
    finish_word(0);
    accept_word(8'hFF, 8'h01, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_in_ready", in_ready, 1);
    check_val("arst_out_valid", out_valid, 0);
    check_val("arst_add_a", add_a, 0);
    check_val("arst_add_b", add_b, 0);
    check_val("arst_add_cin", add_cin, 0);
    check_val("arst_out_idx", out_idx, 0);
    check_val("arst_out_cout", out_cout, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    accept_word(8'h01, 8'h01, 1'b0, 1'b1);
    finish_word(0);

    // 257-word chain, index wraps
    for (int i = 0; i < 257; i++) begin
      accept_word(8'hFF, 8'h01, i == 0, i == 256);
      finish_word(0);
    end

    // random words
    for (int i = 0; i < 40; i++) begin
      accept_word(8'($urandom), 8'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      finish_word($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
